// File: rtl/mod_memrd.sv
// mod_memrd: burst word reader for the byte-banked constant/working RAM.
// Fetches LEN consecutive words from START_ADDR and streams them big-endian
// ({B1,B2,B3,B4}) over VALID/READY through a small credit-managed FIFO.
// Ports:
//   CLK, RST_N              clock, async active-low reset
//   START/START_ADDR/LEN    burst request (LEN 1..DEPTH, range-checked)
//   BUSY/DONE/ERR           burst status, DONE and ERR are one-cycle pulses
//   RAM_RE/RAM_ADDR         read strobe and word address to all four banks
//   RAM_B1..RAM_B4          bank read data, valid the cycle after RAM_RE
//   DATA/VALID/READY        output word stream
module mod_memrd #(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DEPTH      = 72,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] START_ADDR,
  input  logic [ADDR_W:0]   LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              RAM_RE,
  output logic [ADDR_W-1:0] RAM_ADDR,
  input  logic [7:0]        RAM_B1,
  input  logic [7:0]        RAM_B2,
  input  logic [7:0]        RAM_B3,
  input  logic [7:0]        RAM_B4,
  output logic [31:0]       DATA,
  output logic              VALID,
  input  logic              READY
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CHK_W = ADDR_W + 2;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  accepted_q, accepted_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              inflight_q, inflight_d;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [31:0]       fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;

  logic              pop_c;
  logic              push_c;
  logic              issue_c;
  logic              start_bad_c;
  logic [CNT_W:0]    occ_c;
  logic [31:0]       ram_word_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake, RAM return and credit. The issue decision credits this cycle's
  // pop so that a full pipeline still sustains one word per cycle.
  assign ram_word_c  = {RAM_B1, RAM_B2, RAM_B3, RAM_B4};
  assign pop_c       = valid_q && READY;
  assign push_c      = inflight_q;
  assign occ_c       = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop_c);
  assign issue_c     = (state_q == READ) && (issued_q < len_q) &&
                       (occ_c < (CNT_W+1)'(FIFO_DEPTH));
  assign start_bad_c = (LEN == '0) ||
                       ((CHK_W'(START_ADDR) + CHK_W'(LEN)) > CHK_W'(DEPTH));

  // Burst control FSM: next state, counters and status pulses.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    inflight_d = issue_c;
    case (state_q)
      IDLE: begin
        if (START) begin
          if (start_bad_c) begin
            err_d = 1'b1;
          end else begin
            state_d    = READ;
            addr_d     = START_ADDR;
            len_d      = LEN;
            issued_d   = '0;
            accepted_d = '0;
            busy_d     = 1'b1;
          end
        end
      end
      READ: begin
        if (issue_c) begin
          addr_d   = addr_q + ADDR_W'(1);
          issued_d = issued_q + LEN_W'(1);
        end
        if (issued_d == len_q) state_d = DRAIN;
        if (pop_c) accepted_d = accepted_q + LEN_W'(1);
      end
      DRAIN: begin
        if (pop_c) begin
          accepted_d = accepted_q + LEN_W'(1);
          if (accepted_d == len_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output FIFO: circular buffer, simultaneous push and pop allowed.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_c) begin
      fifo_d[wr_ptr_q] = ram_word_c;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop_c) rd_ptr_d = ptr_inc(rd_ptr_q);
    cnt_d   = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    valid_d = (cnt_d != '0);
  end

  // State registers; reset also drops any in-flight read so its push is lost.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign RAM_RE   = issue_c;
  assign RAM_ADDR = addr_q;
  assign DATA     = fifo_q[rd_ptr_q];
  assign VALID    = valid_q;

  // Issue credit must make a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
    !(push_c && !pop_c && (cnt_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_mod_memrd.sv
// Bench for mod_memrd: a behavioural RAM with the H/K table, a queue-based
// reference model checked every cycle, and literal expectations per scenario.
module tb_mod_memrd;

  localparam int unsigned ADDR_W = 7;
  localparam int          DEPTH  = 72;

  localparam logic [31:0] HK [72] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              START;
  logic [ADDR_W-1:0] START_ADDR;
  logic [ADDR_W:0]   LEN;
  logic              BUSY, DONE, ERR, RAM_RE, VALID;
  logic              READY = 1'b0;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [7:0]        RAM_B1, RAM_B2, RAM_B3, RAM_B4;
  logic [31:0]       DATA;
  logic [31:0]       rdata = '0;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int re_cnt   = 0;

  // Reference model state, describing the cycle about to be compared.
  logic [31:0] expq[$];
  logic [31:0] got[$];
  bit          m_busy, m_done, m_err, nb, nd, ne;
  int          m_issued, m_accepted, m_len, m_start;
  bit          prev_stall;
  logic [31:0] prev_data;

  mod_memrd dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .START_ADDR(START_ADDR), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RAM_RE(RAM_RE), .RAM_ADDR(RAM_ADDR),
    .RAM_B1(RAM_B1), .RAM_B2(RAM_B2), .RAM_B3(RAM_B3), .RAM_B4(RAM_B4),
    .DATA(DATA), .VALID(VALID), .READY(READY)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read RAM: data appears the cycle after RAM_RE.
  always @(posedge CLK) if (RAM_RE && int'(RAM_ADDR) < DEPTH) rdata <= HK[RAM_ADDR];
  assign RAM_B1 = rdata[31:24];
  assign RAM_B2 = rdata[23:16];
  assign RAM_B3 = rdata[15:8];
  assign RAM_B4 = rdata[7:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // READY driver: 0 = always ready, 1 = random ~50%, other = stalled.
  initial forever begin
    @(posedge CLK); #1;
    case (rdy_mode)
      0:       READY = 1'b1;
      1:       READY = 1'($urandom % 2);
      default: READY = 1'b0;
    endcase
  end

  // Per-cycle compare against the model, then advance the model.
  initial forever begin
    @(negedge CLK);
    if (!RST_N) begin
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_done", 32'(DONE), 0);
      chk("rst_err", 32'(ERR), 0);
      chk("rst_ram_re", 32'(RAM_RE), 0);
      chk("rst_ram_addr", 32'(RAM_ADDR), 0);
      chk("rst_data", DATA, 0);
      chk("rst_valid", 32'(VALID), 0);
      m_busy = 0; m_done = 0; m_err = 0;
      m_issued = 0; m_accepted = 0; m_len = 0;
      expq.delete();
      prev_stall = 0;
    end else begin
      chk("busy", 32'(BUSY), 32'(m_busy));
      chk("done", 32'(DONE), 32'(m_done));
      chk("err", 32'(ERR), 32'(m_err));
      if (DONE) done_cnt++;
      if (ERR) err_cnt++;
      if (RAM_RE) re_cnt++;
      chk("re_legal", 32'(RAM_RE && !(m_busy && m_issued < m_len)), 0);
      if (RAM_RE) chk("ram_addr", 32'(RAM_ADDR), 32'(m_start + m_issued));
      if (m_busy) chk("occupancy_le2", 32'((m_issued - m_accepted) > 2), 0);
      if (prev_stall) begin
        chk("hold_valid", 32'(VALID), 1);
        chk("hold_data", DATA, prev_data);
      end
      if (VALID && READY) begin
        if (expq.size() == 0) chk("extra_word", 1, 0);
        else chk("word", DATA, expq.pop_front());
        got.push_back(DATA);
      end
      nb = m_busy; nd = 0; ne = 0;
      if (RAM_RE) m_issued++;
      if (VALID && READY && m_busy) begin
        m_accepted++;
        if (m_accepted == m_len) begin nd = 1; nb = 0; end
      end
      if (START && !m_busy) begin
        if (LEN == 0 || int'(START_ADDR) + int'(LEN) > DEPTH) ne = 1;
        else begin
          nb = 1;
          m_start = int'(START_ADDR); m_len = int'(LEN);
          m_issued = 0; m_accepted = 0;
          expq.delete(); got.delete();
          for (int i = 0; i < m_len; i++) expq.push_back(HK[m_start + i]);
        end
      end
      prev_stall = VALID && !READY;
      prev_data  = DATA;
      m_busy = nb; m_done = nd; m_err = ne;
    end
  end

  task automatic start_burst(input int addr, input int len);
    @(posedge CLK); #1;
    START = 1'b1; START_ADDR = ADDR_W'(addr); LEN = (ADDR_W+1)'(len);
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    bit seen = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge CLK);
      seen = DONE;
    end
    chk(name, 32'(seen), 1);
  endtask

  int n, d0, e0, r0;
  logic [31:0] stall_data;

  initial begin
    RST_N = 1'b0; START = 1'b0; START_ADDR = '0; LEN = '0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;

    // 1: LEN 8 from 0 with READY=1, exact latency and back-to-back words.
    rdy_mode = 0;
    start_burst(0, 8);
    @(negedge CLK); chk("t1_re_c0", 32'(RAM_RE), 1); chk("t1_valid_c0", 32'(VALID), 0);
    @(negedge CLK); chk("t1_valid_c1", 32'(VALID), 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk("t1_valid_stream", 32'(VALID), 1);
      if (k == 0) chk("t1_first", DATA, 32'h6a09e667);
      if (k == 7) chk("t1_last", DATA, 32'h5be0cd19);
    end
    @(negedge CLK); chk("t1_done", 32'(DONE), 1); chk("t1_busy_low", 32'(BUSY), 0);

    // 2: full table with random READY.
    rdy_mode = 1;
    start_burst(0, 72);
    wait_done(2000, "t2_timeout");
    chk("t2_count", 32'(got.size()), 72);
    chk("t2_w8", got[8], 32'h428a2f98);
    chk("t2_w9", got[9], 32'h71374491);
    chk("t2_w10", got[10], 32'hb5c0fbcf);
    chk("t2_w71", got[71], 32'hc67178f2);

    // 3: boundary burst and rejected requests.
    rdy_mode = 0;
    start_burst(71, 1);
    wait_done(50, "t3_timeout");
    chk("t3_count", 32'(got.size()), 1);
    chk("t3_word", got[0], 32'hc67178f2);
    repeat (2) @(negedge CLK);
    e0 = err_cnt; r0 = re_cnt;
    start_burst(70, 3);
    repeat (3) @(negedge CLK);
    chk("t3_err_range", 32'(err_cnt - e0), 1);
    chk("t3_no_re", 32'(re_cnt - r0), 0);
    chk("t3_not_busy", 32'(BUSY), 0);
    start_burst(5, 0);
    repeat (3) @(negedge CLK);
    chk("t3_err_len0", 32'(err_cnt - e0), 2);

    // 4: READY held low for 10 cycles mid-burst.
    start_burst(0, 16);
    repeat (4) @(negedge CLK);
    rdy_mode = 2;
    n = 0;
    @(negedge CLK);
    stall_data = DATA;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge CLK);
      if (RAM_RE) n++;
      chk("t4_stall_valid", 32'(VALID), 1);
      chk("t4_stall_data", DATA, stall_data);
    end
    chk("t4_stall_reads_le2", 32'(n <= 2), 1);
    rdy_mode = 0;
    wait_done(100, "t4_timeout");
    chk("t4_count", 32'(got.size()), 16);
    chk("t4_w8", got[8], 32'h428a2f98);

    // 5: reset at word 5 of a LEN 20 burst, then a fresh burst.
    start_burst(0, 20);
    for (int k = 0; k < 100 && got.size() < 5; k++) @(negedge CLK);
    chk("t5_reached_w5", 32'(got.size() >= 5), 1);
    @(posedge CLK); #1 RST_N = 1'b0;
    #1;
    chk("t5_imm_busy", 32'(BUSY), 0);
    chk("t5_imm_re", 32'(RAM_RE), 0);
    chk("t5_imm_valid", 32'(VALID), 0);
    chk("t5_imm_data", DATA, 0);
    chk("t5_imm_addr", 32'(RAM_ADDR), 0);
    d0 = done_cnt;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t5_no_done", 32'(done_cnt - d0), 0);
    start_burst(8, 2);
    wait_done(50, "t5_timeout");
    chk("t5_count", 32'(got.size()), 2);
    chk("t5_w0", got[0], 32'h428a2f98);
    chk("t5_w1", got[1], 32'h71374491);

    // 6: second START during an active burst is ignored.
    rdy_mode = 1;
    d0 = done_cnt; e0 = err_cnt;
    start_burst(0, 8);
    repeat (2) @(posedge CLK);
    #1 START = 1'b1; START_ADDR = ADDR_W'(40); LEN = (ADDR_W+1)'(4);
    @(posedge CLK); #1 START = 1'b0;
    wait_done(200, "t6_timeout");
    repeat (5) @(negedge CLK);
    chk("t6_single_done", 32'(done_cnt - d0), 1);
    chk("t6_no_err", 32'(err_cnt - e0), 0);
    chk("t6_count", 32'(got.size()), 8);
    chk("t6_w0", got[0], 32'h6a09e667);
    chk("t6_w7", got[7], 32'h5be0cd19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual running required finished");
    $fatal(1, "watchdog");
  end

endmodule
